conv_kxk_pipe: RTL and testbench
================================

CONV_KXK_PIPE -- requirements
Module: conv_kxk_pipe

Interface
Parameters:
REQ-001 K, 5, kernel edge; window = K*K taps, K in 2..7.
REQ-002 DW, 9, signed pixel width.
REQ-003 WW, 9, signed coefficient and bias width.
REQ-004 BSHIFT, 8, left shift applied to bias before accumulation.
REQ-005 FRAC, 7, arithmetic right shift applied to accumulator at output.
REQ-006 OW, 12, signed output width.
REQ-007 RELU, 0, 1 = clamp negative results to 0.

Ports:
REQ-008 cnn_clk  in  1  sole clock; all logic rising-edge.
REQ-009 rst  in  1  synchronous reset, active-high.
REQ-010 wt_load  in  1  coefficient word strobe.
REQ-011 wt_data  in  WW  coefficient/bias word, raster order.
REQ-012 coef_ready  out  1  full coefficient set plus bias loaded.
REQ-013 pix_valid  in  1  window present this cycle.
REQ-014 window  in  K*K*DW  tap 0 (top-left) in MSBs, raster order to tap K*K-1 in LSBs.
REQ-015 out_valid  out  1  out_data/sat valid this cycle.
REQ-016 out_data  out  OW  signed result.
REQ-017 sat  out  1  out_data was clipped this result.

Function
REQ-018 Derived: N = K*K+1 terms; S = ceil(log2 N) adder stages; ACCW = DW+WW+S; latency L = S+2 (K=5: L=7).
REQ-019 Load: load index idx starts at 0; each cycle with wt_load=1 and idx<K*K writes coef[idx] and increments idx.
REQ-020 Cycle with wt_load=1 and idx=K*K writes bias, sets coef_ready=1 next cycle, idx holds.
REQ-021 wt_load=1 with coef_ready=1 and idx=K*K: word ignored.
REQ-022 Any cycle with wt_load=0 resets idx to 0; coefficients retained.
REQ-023 First word of a new load (wt_load=1, idx=0) clears coef_ready the following cycle.
REQ-024 Window accepted iff pix_valid=1 and coef_ready=1; otherwise dropped, no out_valid generated.
REQ-025 Stage 1 registers K*K signed products window[i]*coef[i] (DW+WW bits) plus term bias sign-extended and shifted left BSHIFT.
REQ-026 Stages 2..S+1: registered balanced pairwise tree, all signed in ACCW bits; odd term passes through registered.
REQ-027 Stage L: r = acc >>> FRAC; if RELU=1 and r<0, out 0, sat=0; else if r outside signed OW range, out = max/min OW, sat=1; else out = r, sat=0.
REQ-028 out_valid asserts exactly L cycles after accepted window; out_data/sat update only when out_valid=1, else hold.
REQ-029 Throughput one window per cycle; order preserved; no stalls.
REQ-030 Coefficients sampled at stage 1; reload during in-flight windows does not alter them.
REQ-031 Simultaneous wt_load and pix_valid: pixel acceptance uses coef_ready value before this cycle's update.

Reset
REQ-032 rst=1: idx=0, coef_ready=0, all coef and bias=0, valid pipeline cleared, out_valid=0, out_data=0, sat=0.
REQ-033 Reset mid-operation drops all in-flight windows; no out_valid until reload completes and new window accepted.
REQ-034 rst has priority over wt_load and pix_valid in the same cycle.

Verification (K=5, defaults)
REQ-035 Load 25 coefs=128, bias=0; window all taps=3 -> out_valid 7 cycles later, out_data=75, sat=0.
REQ-036 Coefs=0, bias=1, any window -> out_data=2 (256>>>7); coefs=-128, taps=3 -> out_data=-75 (RELU=0), 0 (RELU=1).
REQ-037 Coefs=255, taps=255 -> out_data=2047, sat=1; coefs=-256, taps=255 -> out_data=-2048, sat=1.
REQ-038 10 back-to-back windows with taps=i (i=1..10), coefs=128 -> 10 consecutive out_valid, out_data=25*i*128>>>7=25*i in order.
REQ-039 wt_load dropped after 10 words -> coef_ready=0, pix_valid pulses yield no out_valid; full reload then restores output.
REQ-040 rst pulse with 3 windows in flight -> no out_valid afterwards, coef_ready=0, out_data=0.

Source files
------------

// File: rtl/conv_kxk_pipe.sv
// Pipelined KxK signed convolution: one window per cycle, products plus shifted bias
// reduced through a registered pairwise adder tree, then shifted, optionally ReLU'd and clipped.
module conv_kxk_pipe #(
   parameter int K      = 5,
   parameter int DW     = 9,
   parameter int WW     = 9,
   parameter int BSHIFT = 8,
   parameter int FRAC   = 7,
   parameter int OW     = 12,
   parameter int RELU   = 0
) (
   input  logic                    cnn_clk,
   input  logic                    rst,
   input  logic                    wt_load,
   input  logic signed [WW-1:0]    wt_data,
   output logic                    coef_ready,
   input  logic                    pix_valid,
   input  logic [K*K*DW-1:0]       window,
   output logic                    out_valid,
   output logic signed [OW-1:0]    out_data,
   output logic                    sat
);

   localparam int NT   = K * K;
   localparam int N    = NT + 1;
   localparam int S    = $clog2(N);
   localparam int ACCW = DW + WW + S;
   localparam int IW   = $clog2(NT + 1);

   localparam longint              OMAX   = (longint'(1) <<< (OW - 1)) - 1;
   localparam longint              OMIN   = -(longint'(1) <<< (OW - 1));
   localparam logic [OW-1:0]       OMAX_V = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0]       OMIN_V = {1'b1, {(OW-1){1'b0}}};

   // Number of live terms entering tree level lvl (level 0 = stage-1 registers).
   function automatic int cnt_at(input int lvl);
      int c;
      c = N;
      for (int j = 0; j < lvl; j++) c = (c + 1) / 2;
      return c;
   endfunction

   function automatic logic signed [ACCW-1:0] mul_term(input logic signed [DW-1:0] px,
                                                       input logic signed [WW-1:0] cf);
      logic signed [DW+WW-1:0] p;
      p = px * cf;
      return ACCW'(p);
   endfunction

   function automatic logic signed [ACCW-1:0] bias_term(input logic signed [WW-1:0] bv);
      logic signed [ACCW-1:0] b;
      b = ACCW'(bv);
      return b <<< BSHIFT;
   endfunction

   // Returns {sat, data}: arithmetic shift, optional ReLU, then clip to the OW range.
   function automatic logic [OW:0] clip(input logic signed [ACCW-1:0] acc);
      logic signed [ACCW-1:0] r;
      r = acc >>> FRAC;
      if (RELU != 0 && r < 0)
         return '0;
      else if (longint'(r) > OMAX)
         return {1'b1, OMAX_V};
      else if (longint'(r) < OMIN)
         return {1'b1, OMIN_V};
      else
         return {1'b0, r[OW-1:0]};
   endfunction

   logic [IW-1:0]          idx_q, idx_d;
   logic                   ready_q, ready_d;
   logic                   coef_we, bias_we;
   logic signed [WW-1:0]   coef_q [0:NT-1];
   logic signed [WW-1:0]   bias_q;

   // The last word of a load (idx == NT) is the bias; once ready, further words are ignored.
   always_comb begin
      idx_d   = idx_q;
      ready_d = ready_q;
      coef_we = 1'b0;
      bias_we = 1'b0;
      if (!wt_load) begin
         idx_d = '0;
      end else if (idx_q < IW'(NT)) begin
         coef_we = 1'b1;
         idx_d   = idx_q + 1'b1;
         if (idx_q == '0) ready_d = 1'b0;
      end else if (!ready_q) begin
         bias_we = 1'b1;
         ready_d = 1'b1;
      end
   end

   always_ff @(posedge cnn_clk) begin
      if (rst) begin
         idx_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         ready_q <= ready_d;
      end
   end

   always_ff @(posedge cnn_clk) begin
      if (rst) begin
         for (int i = 0; i < NT; i++) coef_q[i] <= '0;
         bias_q <= '0;
      end else begin
         if (coef_we) coef_q[idx_q] <= wt_data;
         if (bias_we) bias_q <= wt_data;
      end
   end

   logic                   accept;
   logic [S:0]             vld_q;
   logic signed [ACCW-1:0] tree_q [0:S][0:N-1];

   // Acceptance uses ready_q before this cycle's load update.
   assign accept = pix_valid & ready_q;

   always_ff @(posedge cnn_clk) begin
      if (rst) vld_q <= '0;
      else     vld_q <= {vld_q[S-1:0], accept};
   end

   // ---- stage 1: products and bias term
   always_ff @(posedge cnn_clk) begin
      for (int i = 0; i < NT; i++)
         tree_q[0][i] <= mul_term(window[(NT-1-i)*DW +: DW], coef_q[i]);
      tree_q[0][NT] <= bias_term(bias_q);
   end

   // ---- stages 2..S+1: registered pairwise reduction, odd term passes through
   for (genvar j = 1; j <= S; j++) begin : g_lvl
      localparam int PC = cnt_at(j - 1);
      for (genvar i = 0; i < N; i++) begin : g_node
         if (2*i + 1 < PC) begin : g_add
            always_ff @(posedge cnn_clk)
               tree_q[j][i] <= tree_q[j-1][2*i] + tree_q[j-1][2*i+1];
         end else if (2*i < PC) begin : g_pass
            always_ff @(posedge cnn_clk)
               tree_q[j][i] <= tree_q[j-1][2*i];
         end else begin : g_idle
            always_ff @(posedge cnn_clk)
               tree_q[j][i] <= '0;
         end
      end
   end

   logic                 out_valid_q;
   logic signed [OW-1:0] out_data_q;
   logic                 sat_q;

   // ---- stage L: shift, ReLU, saturate; result held between valid cycles
   always_ff @(posedge cnn_clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sat_q       <= 1'b0;
      end else begin
         out_valid_q <= vld_q[S];
         if (vld_q[S]) {sat_q, out_data_q} <= clip(tree_q[S][0]);
      end
   end

   assign coef_ready = ready_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign sat        = sat_q;

endmodule

// File: tb/tb_conv_kxk_pipe.sv
// Directed bench for conv_kxk_pipe (K=5 defaults); a second instance runs with RELU=1.
module tb_conv_kxk_pipe;

   localparam int K  = 5;
   localparam int DW = 9;
   localparam int WW = 9;
   localparam int OW = 12;
   localparam int NT = K * K;
   localparam int L  = 7;

   logic                 cnn_clk = 1'b0;
   logic                 rst, wt_load, pix_valid;
   logic signed [WW-1:0] wt_data;
   logic [NT*DW-1:0]     window;
   logic                 coef_ready, out_valid, sat;
   logic signed [OW-1:0] out_data;
   logic                 r_coef_ready, r_out_valid, r_sat;
   logic signed [OW-1:0] r_out_data;

   int n_tests = 0;
   int n_fail  = 0;
   int coef_tb [NT];

   always #5 cnn_clk = ~cnn_clk;

   conv_kxk_pipe #(.K(K), .DW(DW), .WW(WW), .BSHIFT(8), .FRAC(7), .OW(OW), .RELU(0)) dut (
      .cnn_clk(cnn_clk), .rst(rst), .wt_load(wt_load), .wt_data(wt_data),
      .coef_ready(coef_ready), .pix_valid(pix_valid), .window(window),
      .out_valid(out_valid), .out_data(out_data), .sat(sat));

   conv_kxk_pipe #(.K(K), .DW(DW), .WW(WW), .BSHIFT(8), .FRAC(7), .OW(OW), .RELU(1)) dut_relu (
      .cnn_clk(cnn_clk), .rst(rst), .wt_load(wt_load), .wt_data(wt_data),
      .coef_ready(r_coef_ready), .pix_valid(pix_valid), .window(window),
      .out_valid(r_out_valid), .out_data(r_out_data), .sat(r_sat));

   task automatic tick();
      @(posedge cnn_clk);
      #1;
   endtask

   task automatic set_all_taps(input int v);
      for (int i = 0; i < NT; i++) window[i*DW +: DW] = DW'(v);
   endtask

   task automatic load_arr(input int b, input int extra_n, input int extra_v);
      wt_load = 1'b1;
      for (int i = 0; i < NT; i++) begin
         wt_data = WW'(coef_tb[i]);
         tick();
      end
      wt_data = WW'(b);
      tick();
      for (int i = 0; i < extra_n; i++) begin
         wt_data = WW'(extra_v);
         tick();
      end
      wt_load = 1'b0;
   endtask

   task automatic load_uniform(input int c, input int b);
      for (int i = 0; i < NT; i++) coef_tb[i] = c;
      load_arr(b, 0, 0);
   endtask

   // Presents one window and waits (bounded) for its result; lat counts cycles after acceptance.
   task automatic send_one(output int lat, output logic signed [OW-1:0] d, output logic s,
                           output logic signed [OW-1:0] rd, output logic rs);
      pix_valid = 1'b1;
      tick();
      pix_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      d  = out_data;
      s  = sat;
      rd = r_out_data;
      rs = r_sat;
   endtask

   task automatic test_reset();
      rst = 1'b1; wt_load = 1'b0; pix_valid = 1'b0; wt_data = '0; window = '0;
      tick();
      tick();
      n_tests++; if (coef_ready !== 1'b0) begin n_fail++; $display("FAIL reset_coef_ready got %b want 0", coef_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_tests++; if (out_data !== 12'sd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_data); end
      n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b want 0", sat); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int lat; logic signed [OW-1:0] d, rd; logic s, rs;
      load_uniform(128, 0);
      n_tests++; if (coef_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %b want 1", coef_ready); end
      set_all_taps(3);
      send_one(lat, d, s, rd, rs);
      n_tests++; if (lat != L - 1) begin n_fail++; $display("FAIL basic_latency got %0d want %0d", lat + 1, L); end
      n_tests++; if (d !== 12'sd75) begin n_fail++; $display("FAIL basic_data got %0d want 75", d); end
      n_tests++; if (s !== 1'b0) begin n_fail++; $display("FAIL basic_sat got %b want 0", s); end
      n_tests++; if (rd !== 12'sd75) begin n_fail++; $display("FAIL basic_relu_data got %0d want 75", rd); end
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_single_pulse got %b want 0", out_valid); end
      n_tests++; if (out_data !== 12'sd75) begin n_fail++; $display("FAIL basic_hold got %0d want 75", out_data); end
   endtask

   task automatic test_bias();
      int lat; logic signed [OW-1:0] d, rd; logic s, rs;
      for (int i = 0; i < NT; i++) coef_tb[i] = 0;
      load_arr(1, 1, 50);
      set_all_taps(77);
      send_one(lat, d, s, rd, rs);
      n_tests++; if (d !== 12'sd2) begin n_fail++; $display("FAIL bias_pos got %0d want 2", d); end
      load_arr(-1, 0, 0);
      send_one(lat, d, s, rd, rs);
      n_tests++; if (d !== -12'sd2) begin n_fail++; $display("FAIL bias_neg got %0d want -2", d); end
      n_tests++; if (rd !== 12'sd0) begin n_fail++; $display("FAIL bias_neg_relu got %0d want 0", rd); end
   endtask

   task automatic test_negative();
      int lat; logic signed [OW-1:0] d, rd; logic s, rs;
      load_uniform(-128, 0);
      set_all_taps(3);
      send_one(lat, d, s, rd, rs);
      n_tests++; if (d !== -12'sd75) begin n_fail++; $display("FAIL neg_data got %0d want -75", d); end
      n_tests++; if (s !== 1'b0) begin n_fail++; $display("FAIL neg_sat got %b want 0", s); end
      n_tests++; if (rd !== 12'sd0) begin n_fail++; $display("FAIL neg_relu_data got %0d want 0", rd); end
      n_tests++; if (rs !== 1'b0) begin n_fail++; $display("FAIL neg_relu_sat got %b want 0", rs); end
   endtask

   task automatic test_saturation();
      int lat; logic signed [OW-1:0] d, rd; logic s, rs;
      load_uniform(255, 0);
      set_all_taps(255);
      send_one(lat, d, s, rd, rs);
      n_tests++; if (d !== 12'sd2047) begin n_fail++; $display("FAIL sat_pos_data got %0d want 2047", d); end
      n_tests++; if (s !== 1'b1) begin n_fail++; $display("FAIL sat_pos_flag got %b want 1", s); end
      n_tests++; if (rs !== 1'b1) begin n_fail++; $display("FAIL sat_pos_relu_flag got %b want 1", rs); end
      load_uniform(-256, 0);
      send_one(lat, d, s, rd, rs);
      n_tests++; if (d !== -12'sd2048) begin n_fail++; $display("FAIL sat_neg_data got %0d want -2048", d); end
      n_tests++; if (s !== 1'b1) begin n_fail++; $display("FAIL sat_neg_flag got %b want 1", s); end
      n_tests++; if (rd !== 12'sd0 || rs !== 1'b0) begin n_fail++; $display("FAIL sat_neg_relu got %0d/%b want 0/0", rd, rs); end
   endtask

   task automatic test_tap_order();
      int lat; logic signed [OW-1:0] d, rd; logic s, rs;
      for (int i = 0; i < NT; i++) coef_tb[i] = 0;
      coef_tb[0]      = 128;
      coef_tb[NT - 1] = -128;
      load_arr(0, 0, 0);
      set_all_taps(100);
      window[(NT-1)*DW +: DW] = DW'(10);
      send_one(lat, d, s, rd, rs);
      n_tests++; if (d !== -12'sd90) begin n_fail++; $display("FAIL tap_order got %0d want -90", d); end
   endtask

   task automatic test_back_to_back();
      int nout = 0;
      int vals [10];
      int cyc [10];
      load_uniform(128, 0);
      for (int c = 0; c < 30; c++) begin
         if (c < 10) begin
            set_all_taps(c + 1);
            pix_valid = 1'b1;
         end else begin
            pix_valid = 1'b0;
         end
         tick();
         if (out_valid) begin
            if (nout < 10) begin
               vals[nout] = int'(out_data);
               cyc[nout]  = c;
            end
            nout++;
         end
      end
      n_tests++; if (nout != 10) begin n_fail++; $display("FAIL b2b_count got %0d want 10", nout); end
      for (int k = 0; k < 10 && k < nout; k++) begin
         n_tests++; if (vals[k] != 25 * (k + 1)) begin n_fail++; $display("FAIL b2b_data[%0d] got %0d want %0d", k, vals[k], 25 * (k + 1)); end
         n_tests++; if (cyc[k] != L - 1 + k) begin n_fail++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", k, cyc[k], L - 1 + k); end
      end
   endtask

   task automatic test_partial_load();
      int lat; int nout = 0; logic signed [OW-1:0] d, rd; logic s, rs;
      wt_load = 1'b1;
      wt_data = WW'(7);
      for (int i = 0; i < 10; i++) tick();
      wt_load = 1'b0;
      tick();
      n_tests++; if (coef_ready !== 1'b0) begin n_fail++; $display("FAIL partial_ready got %b want 0", coef_ready); end
      set_all_taps(3);
      for (int c = 0; c < 18; c++) begin
         pix_valid = (c < 3);
         tick();
         if (out_valid) nout++;
      end
      pix_valid = 1'b0;
      n_tests++; if (nout != 0) begin n_fail++; $display("FAIL partial_dropped got %0d outputs want 0", nout); end
      load_uniform(128, 0);
      send_one(lat, d, s, rd, rs);
      n_tests++; if (d !== 12'sd75 || lat != L - 1) begin n_fail++; $display("FAIL partial_restore got %0d lat %0d want 75 lat %0d", d, lat + 1, L); end
   endtask

   task automatic test_reload_inflight();
      int lat; int nout = 0; int first = 0; logic signed [OW-1:0] d, rd; logic s, rs;
      set_all_taps(3);
      for (int c = 0; c < 40; c++) begin
         wt_load   = (c < 26);
         wt_data   = (c < 25) ? -9'sd128 : 9'sd0;
         pix_valid = (c == 0 || c == 3);
         tick();
         if (out_valid) begin
            if (nout == 0) first = int'(out_data);
            nout++;
         end
      end
      wt_load = 1'b0; pix_valid = 1'b0;
      n_tests++; if (nout != 1) begin n_fail++; $display("FAIL reload_count got %0d want 1", nout); end
      n_tests++; if (first != 75) begin n_fail++; $display("FAIL reload_old_coefs got %0d want 75", first); end
      send_one(lat, d, s, rd, rs);
      n_tests++; if (d !== -12'sd75) begin n_fail++; $display("FAIL reload_new_coefs got %0d want -75", d); end
   endtask

   task automatic test_reset_inflight();
      int nout = 0;
      load_uniform(128, 0);
      set_all_taps(3);
      pix_valid = 1'b1;
      for (int c = 0; c < 3; c++) tick();
      pix_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 15; c++) begin
         pix_valid = 1'b1;
         tick();
         if (out_valid) nout++;
      end
      pix_valid = 1'b0;
      n_tests++; if (nout != 0) begin n_fail++; $display("FAIL rst_inflight_outputs got %0d want 0", nout); end
      n_tests++; if (coef_ready !== 1'b0) begin n_fail++; $display("FAIL rst_inflight_ready got %b want 0", coef_ready); end
      n_tests++; if (out_data !== 12'sd0) begin n_fail++; $display("FAIL rst_inflight_data got %0d want 0", out_data); end
      n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL rst_inflight_sat got %b want 0", sat); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bias();
      test_negative();
      test_saturation();
      test_tap_order();
      test_back_to_back();
      test_partial_load();
      test_reload_inflight();
      test_reset_inflight();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
